// File: rtl/pow_defs.sv
// Shared PoW definitions: balanced-trit codes, chunk geometry and FSM encodings.
package pow_defs;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_ILL  = 2'b10;

  localparam int CHUNK_TRITS = 27;
  localparam int CHUNK_BITS  = 2 * CHUNK_TRITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_OFFER = 2'd2
  } state_e;

  // Legal codes pass through; the one unused code collapses to zero.
  function automatic logic [1:0] sanitize_trit(input logic [1:0] trit);
    case (trit)
      TRIT_ZERO, TRIT_POS, TRIT_NEG: sanitize_trit = trit;
      default:                       sanitize_trit = TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/trit_sanitize.sv
// Combinational clean-up of one 27-trit chunk: illegal codes become zero and are flagged.
module trit_sanitize
  import pow_defs::*;
(
  input  logic [CHUNK_BITS-1:0] trits_in,
  output logic [CHUNK_BITS-1:0] trits_out,
  output logic                  any_illegal
);

  logic [CHUNK_TRITS-1:0] illegal;

  generate
    for (genvar gi = 0; gi < CHUNK_TRITS; gi++) begin : g_trit
      assign trits_out[2*gi +: 2] = sanitize_trit(trits_in[2*gi +: 2]);
      assign illegal[gi]          = (trits_in[2*gi +: 2] == TRIT_ILL);
    end
  endgenerate

  assign any_illegal = |illegal;

endmodule

// File: rtl/nonce_assembler.sv
// Builds 81-trit nonce candidates from 27-trit LFSR chunks and offers them to Curl over valid/ready.
module nonce_assembler
  import pow_defs::*;
#(
  parameter int NONCE_TRITS = 81,
  parameter int CNT_W       = 32
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [CHUNK_BITS-1:0]    i_rnd_trits,
  input  logic                     i_start,
  input  logic                     i_stop,
  output logic [2*NONCE_TRITS-1:0] o_nonce,
  output logic                     o_nonce_valid,
  input  logic                     i_nonce_ready,
  output logic                     o_busy,
  output logic [CNT_W-1:0]         o_attempt_cnt,
  output logic                     o_illegal_err
);

  localparam int CHUNKS = NONCE_TRITS / CHUNK_TRITS;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_e                     state_reg;
  logic [IDX_W-1:0]           chunk_idx_reg;
  logic                       stop_pending_reg;
  logic [2*NONCE_TRITS-1:0]   nonce_reg;
  logic                       valid_reg;
  logic                       busy_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic                       err_reg;

  logic [CHUNK_BITS-1:0]      clean_chunk;
  logic                       chunk_illegal;

  trit_sanitize u_sanitize (
    .trits_in    (i_rnd_trits),
    .trits_out   (clean_chunk),
    .any_illegal (chunk_illegal)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_reg        <= ST_IDLE;
      chunk_idx_reg    <= '0;
      stop_pending_reg <= 1'b0;
      nonce_reg        <= '0;
      valid_reg        <= 1'b0;
      busy_reg         <= 1'b0;
      cnt_reg          <= '0;
      err_reg          <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // A simultaneous stop vetoes the start.
          if (i_start && !i_stop) begin
            state_reg     <= ST_FILL;
            busy_reg      <= 1'b1;
            chunk_idx_reg <= '0;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
          end
        end

        ST_FILL: begin
          if (i_stop) begin
            // Partial nonce is abandoned; o_nonce keeps stale data behind a low valid.
            state_reg        <= ST_IDLE;
            busy_reg         <= 1'b0;
            stop_pending_reg <= 1'b0;
          end else begin
            nonce_reg[int'(chunk_idx_reg)*CHUNK_BITS +: CHUNK_BITS] <= clean_chunk;
            if (chunk_illegal) begin
              err_reg <= 1'b1;
            end
            if (chunk_idx_reg == LAST_IDX) begin
              state_reg     <= ST_OFFER;
              valid_reg     <= 1'b1;
              chunk_idx_reg <= '0;
            end else begin
              chunk_idx_reg <= chunk_idx_reg + 1'b1;
            end
          end
        end

        ST_OFFER: begin
          if (i_nonce_ready) begin
            valid_reg     <= 1'b0;
            chunk_idx_reg <= '0;
            if (~&cnt_reg) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
            // A stop seen on the handshake edge itself is treated like a pending one.
            if (stop_pending_reg || i_stop) begin
              state_reg        <= ST_IDLE;
              busy_reg         <= 1'b0;
              stop_pending_reg <= 1'b0;
            end else begin
              state_reg <= ST_FILL;
            end
          end else if (i_stop) begin
            stop_pending_reg <= 1'b1;
          end
        end

        default: begin
          state_reg        <= ST_IDLE;
          busy_reg         <= 1'b0;
          valid_reg        <= 1'b0;
          stop_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_nonce       = nonce_reg;
  assign o_nonce_valid = valid_reg;
  assign o_busy        = busy_reg;
  assign o_attempt_cnt = cnt_reg;
  assign o_illegal_err = err_reg;

endmodule

// File: tb/tb_nonce_assembler.sv
// Randomized scoreboard bench for nonce_assembler: transaction-level model feeds a queue, a monitor checks.
module tb_nonce_assembler;

  localparam int NT = 81;
  localparam int CW = 4;
  localparam int CH = NT / 27;
  localparam int NB = 2 * NT;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          ready = 1'b0;
  logic [53:0]   rnd = '0;
  logic [NB-1:0] nonce;
  logic          nonce_valid;
  logic          busy;
  logic [CW-1:0] attempt_cnt;
  logic          illegal_err;

  nonce_assembler #(.NONCE_TRITS(NT), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_arst_n      (arst_n),
    .i_rnd_trits   (rnd),
    .i_start       (start),
    .i_stop        (stop),
    .o_nonce       (nonce),
    .o_nonce_valid (nonce_valid),
    .i_nonce_ready (ready),
    .o_busy        (busy),
    .o_attempt_cnt (attempt_cnt),
    .o_illegal_err (illegal_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  typedef struct {
    logic [NB-1:0] nonce;
    logic          err;
    int            cnt;
  } exp_t;
  exp_t exp_q[$];

  // Transaction-level model: 0 idle, 1 collecting chunks, 2 offering.
  int          m_phase = 0;
  logic [53:0] m_got[$];
  bit          m_stop_req = 0;
  int          m_cnt = 0;
  bit          m_err = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [53:0] clean54(input logic [53:0] r);
    logic [1:0] t;
    logic [53:0] o;
    for (int i = 0; i < 27; i++) begin
      t = r[2*i +: 2];
      o[2*i +: 2] = (t == 2'b10) ? 2'b00 : t;
    end
    return o;
  endfunction

  function automatic bit has_ill(input logic [53:0] r);
    for (int i = 0; i < 27; i++)
      if (r[2*i +: 2] == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [53:0] legal_rnd();
    logic [53:0] o;
    for (int i = 0; i < 27; i++) begin
      case ($urandom_range(2))
        0:       o[2*i +: 2] = 2'b00;
        1:       o[2*i +: 2] = 2'b01;
        default: o[2*i +: 2] = 2'b11;
      endcase
    end
    return o;
  endfunction

  function automatic logic [53:0] any_rnd();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[53:0];
  endfunction

  initial begin : model
    logic [NB-1:0] n;
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
        m_phase = 0; m_got.delete(); m_stop_req = 0; m_cnt = 0; m_err = 0;
        exp_q.delete();
      end else begin
        case (m_phase)
          0: if (start && !stop) begin
               m_phase = 1; m_got.delete(); m_cnt = 0; m_err = 0;
             end
          1: if (stop) begin
               m_phase = 0; m_got.delete();
             end else begin
               m_got.push_back(clean54(rnd));
               if (has_ill(rnd)) m_err = 1;
               if (m_got.size() == CH) begin
                 n = '0;
                 for (int j = 0; j < CH; j++) n[54*j +: 54] = m_got[j];
                 exp_q.push_back('{nonce: n, err: m_err, cnt: m_cnt});
                 m_got.delete();
                 m_phase = 2;
               end
             end
          default: if (ready) begin
               if (m_cnt < CNT_MAX) m_cnt++;
               m_phase = (m_stop_req || stop) ? 0 : 1;
               m_stop_req = 0;
             end else if (stop) begin
               m_stop_req = 1;
             end
        endcase
        if (m_phase == 0) m_stop_req = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (arst_n) begin
        chk("valid", nonce_valid, (m_phase == 2));
        chk("busy", busy, (m_phase != 0));
        chk("cnt", attempt_cnt, m_cnt[CW-1:0]);
        chk("err", illegal_err, m_err);
        if (nonce_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1'b1, 1'b0);
          end else begin
            chk("nonce", nonce, exp_q[0].nonce);
            if (ready) begin
              chk("hs_err", illegal_err, exp_q[0].err);
              chk("hs_cnt", attempt_cnt, exp_q[0].cnt[CW-1:0]);
              txn++;
              $display("txn %0d: nonce=%h cnt_before=%0d err=%0d", txn, nonce, attempt_cnt, illegal_err);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic step(input logic st, input logic sp, input logic rd, input logic [53:0] r);
    @(posedge clk);
    #2;
    start = st; stop = sp; ready = rd; rnd = r;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_nonce"}, nonce, '0);
    chk({tag, "_valid"}, nonce_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_cnt"}, attempt_cnt, '0);
    chk({tag, "_err"}, illegal_err, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    start = 0; stop = 0; ready = 0;
    #1 arst_n = 1'b0;
    #1 reset_check(tag);
    @(posedge clk);
    #3 arst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0, 0, any_rnd());
    chk({tag, "_no_valid"}, nonce_valid, 1'b0);
  endtask

  initial begin : stimulus
    logic [NB-1:0] fill_exp;
    logic [53:0]   all_pos, all_neg, all_ill;
    all_pos = 54'h15_5555_5555_5555;
    all_neg = 54'h3F_FFFF_FFFF_FFFF;
    all_ill = 54'h2A_AAAA_AAAA_AAAA;
    fill_exp = {all_neg, all_pos, 54'h0};

    #12 reset_check("reset");
    #10 arst_n = 1'b1;

    // Fill order, then backpressure.
    step(1, 0, 0, legal_rnd());
    step(0, 0, 0, 54'h0);
    step(0, 0, 0, all_pos);
    step(0, 0, 0, all_neg);
    step(0, 0, 0, any_rnd());
    chk("fill_valid", nonce_valid, 1'b1);
    chk("fill_nonce", nonce, fill_exp);
    chk("fill_err", illegal_err, 1'b0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, any_rnd());
    chk("bp_nonce", nonce, fill_exp);
    step(0, 0, 1, any_rnd());
    step(0, 0, 0, legal_rnd());
    chk("bp_cnt", attempt_cnt, 4'd1);
    chk("bp_valid_low", nonce_valid, 1'b0);

    // Illegal codes in the middle chunk.
    step(0, 0, 0, all_ill);
    step(0, 0, 0, legal_rnd());
    step(0, 0, 0, legal_rnd());
    chk("ill_valid_again", nonce_valid, 1'b1);
    chk("ill_mid_zero", nonce[107:54], 54'h0);
    chk("ill_err", illegal_err, 1'b1);
    step(0, 0, 1, legal_rnd());
    for (int i = 0; i < 3; i++) step(0, 0, 0, legal_rnd());
    chk("ill_sticky", illegal_err, 1'b1);

    // Stop during OFFER: offer held until the handshake, then idle.
    step(0, 1, 0, legal_rnd());
    for (int i = 0; i < 3; i++) step(0, 0, 0, legal_rnd());
    chk("offer_stop_held", nonce_valid, 1'b1);
    step(0, 0, 1, legal_rnd());
    step(0, 0, 0, legal_rnd());
    chk("offer_stop_busy", busy, 1'b0);
    chk("offer_stop_cnt", attempt_cnt, 4'd3);

    // Start and stop together: stays idle, flag not cleared.
    step(1, 1, 0, legal_rnd());
    step(0, 0, 0, legal_rnd());
    chk("startstop_busy", busy, 1'b0);
    chk("startstop_err", illegal_err, 1'b1);

    // Accepted start clears flag and counter; stop after one chunk.
    step(1, 0, 0, legal_rnd());
    step(0, 0, 0, legal_rnd());
    chk("restart_busy", busy, 1'b1);
    chk("restart_err", illegal_err, 1'b0);
    chk("restart_cnt", attempt_cnt, 4'd0);
    step(0, 1, 0, legal_rnd());
    step(0, 0, 0, legal_rnd());
    chk("fill_stop_busy", busy, 1'b0);
    chk("fill_stop_valid", nonce_valid, 1'b0);

    // Streaming with ready tied high.
    step(1, 0, 0, legal_rnd());
    for (int i = 0; i < 40; i++) step(0, 0, 1, legal_rnd());
    step(0, 1, 0, legal_rnd());
    chk("stream_cnt", attempt_cnt, 4'd10);
    step(0, 0, 0, legal_rnd());

    // Counter saturation, fully random trit codes.
    step(1, 0, 0, any_rnd());
    for (int i = 0; i < 80; i++) step(0, 0, 1, any_rnd());
    step(0, 1, 0, any_rnd());
    chk("sat_cnt", attempt_cnt, 4'd15);
    step(0, 0, 0, any_rnd());

    // Asynchronous reset mid-FILL and mid-OFFER.
    step(1, 0, 0, legal_rnd());
    step(0, 0, 0, legal_rnd());
    step(0, 0, 0, legal_rnd());
    async_reset("rst_fill");
    step(1, 0, 0, legal_rnd());
    for (int i = 0; i < 3; i++) step(0, 0, 0, legal_rnd());
    step(0, 0, 0, legal_rnd());
    chk("pre_rst_offer_valid", nonce_valid, 1'b1);
    async_reset("rst_offer");

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
